l2_trace_dispatch: RTL and testbench

Front-end stage directly upstream of the L2 cache. Accepts trace records (command code + address) from the bench trace reader over valid/ready and buffers them in a FIFO. Decodes each record into one L2 operation: L1-side DR/DW/IR, snoop R/W/M/I, or clear. Issues operations to the L2 one at a time with a req/ack handshake and keeps saturating read/write/hit/miss statistics.

---
 rtl/l2_trace_pkg.sv | 67 ++++++
 rtl/l2_trace_fifo.sv | 59 +++++
 rtl/l2_trace_dispatch.sv | 199 +++++++++++++++++++
 tb/tb_l2_trace_dispatch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_trace_pkg.sv
// Shared types for the L2 trace dispatcher: trace command codes, L2 op encodings,
// the FIFO entry layout and the command decoder.
package l2_trace_pkg;

    localparam int unsigned TRACE_ADDR_W = 32;
    localparam int unsigned TRACE_CMD_W  = 4;
    localparam int unsigned L2_OP_W      = 3;

    typedef enum logic [TRACE_CMD_W-1:0] {
        CMD_DR    = 4'd0,
        CMD_DW    = 4'd1,
        CMD_IR    = 4'd2,
        CMD_SI    = 4'd3,
        CMD_SR    = 4'd4,
        CMD_SW    = 4'd5,
        CMD_SM    = 4'd6,
        CMD_RSVD  = 4'd7,
        CMD_CLR   = 4'd8,
        CMD_PRINT = 4'd9
    } trace_cmd_e;

    typedef enum logic [L2_OP_W-1:0] {
        OP_DR  = 3'd0,
        OP_DW  = 3'd1,
        OP_IR  = 3'd2,
        OP_SI  = 3'd3,
        OP_SR  = 3'd4,
        OP_SW  = 3'd5,
        OP_SM  = 3'd6,
        OP_CLR = 3'd7
    } l2_op_e;

    // Raw command is kept so illegal codes 10-15 survive the FIFO unchanged.
    typedef struct packed {
        logic [TRACE_CMD_W-1:0]  cmd;
        logic [TRACE_ADDR_W-1:0] addr;
    } trace_entry_t;

    typedef struct packed {
        logic   valid;
        l2_op_e op;
    } op_dec_t;

    // Map a trace command to an L2 op; print and illegal codes come back invalid.
    function automatic op_dec_t decode_cmd(input logic [TRACE_CMD_W-1:0] cmd);
        op_dec_t d;
        d.valid = 1'b1;
        d.op    = OP_DR;
        case (cmd)
            CMD_DR:  d.op = OP_DR;
            CMD_DW:  d.op = OP_DW;
            CMD_IR:  d.op = OP_IR;
            CMD_SI:  d.op = OP_SI;
            CMD_SR:  d.op = OP_SR;
            CMD_SW:  d.op = OP_SW;
            CMD_SM:  d.op = OP_SM;
            CMD_CLR: d.op = OP_CLR;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_l1_op(input l2_op_e op);
        return (op == OP_DR) || (op == OP_DW) || (op == OP_IR);
    endfunction

endpackage

// File: rtl/l2_trace_fifo.sv
// Synchronous FIFO for trace records; push is refused when full even if a pop
// happens in the same cycle, and there is no write-to-read bypass.
module l2_trace_fifo
    import l2_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type entry_t = trace_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/l2_trace_dispatch.sv
// Trace front-end for the L2: buffers trace records, decodes them into L2 ops issued
// one at a time over req/ack, and keeps saturating statistics.
// Define L2_TRACE_DISPATCH_LOG_EN to compile in simulation logging of ops and stats.
module l2_trace_dispatch
    import l2_trace_pkg::*;
#(
    parameter int unsigned ADDR_W = TRACE_ADDR_W,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TRACE_CMD_W-1:0] in_cmd,
    input  logic [ADDR_W-1:0]      in_addr,
    output logic                   l2_req,
    output logic [L2_OP_W-1:0]     l2_op,
    output logic [ADDR_W-1:0]      l2_addr,
    input  logic                   l2_ack,
    input  logic                   l2_hit,
    output logic                   print_stb,
    output logic [CNT_W-1:0]       read_cnt,
    output logic [CNT_W-1:0]       write_cnt,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    typedef struct packed {
        logic [TRACE_CMD_W-1:0] cmd;
        logic [ADDR_W-1:0]      addr;
    } entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e            state_q;
    logic              l2_req_q;
    l2_op_e            l2_op_q;
    logic [ADDR_W-1:0] l2_addr_q;
    logic              print_stb_q;
    logic [CNT_W-1:0]  read_q,  read_d;
    logic [CNT_W-1:0]  write_q, write_d;
    logic [CNT_W-1:0]  hit_q,   hit_d;
    logic [CNT_W-1:0]  miss_q,  miss_d;
    logic [CNT_W-1:0]  err_q,   err_d;

    entry_t  push_entry;
    entry_t  head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    pop;
    logic    head_print;
    op_dec_t dec;
    logic    issue;
    logic    illegal;
    logic    ack_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign push_entry.cmd  = in_cmd;
    assign push_entry.addr = in_addr;

    l2_trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready   = !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign head_print = (head.cmd == CMD_PRINT);
    assign dec        = decode_cmd(head.cmd);
    assign issue      = pop && !head_print && dec.valid;
    assign illegal    = pop && !head_print && !dec.valid;
    assign ack_done   = (state_q == ST_REQ) && l2_ack;

    // Dispatch FSM: pop in IDLE, hold the request in REQ until acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            l2_req_q    <= 1'b0;
            l2_op_q     <= OP_DR;
            l2_addr_q   <= '0;
            print_stb_q <= 1'b0;
        end else begin
            print_stb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop && head_print) begin
                        print_stb_q <= 1'b1;
                    end else if (issue) begin
                        l2_op_q   <= dec.op;
                        l2_addr_q <= head.addr;
                        l2_req_q  <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (l2_ack) begin
                        l2_req_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Statistics; a clear op overrides any increment on the same edge.
    always_comb begin
        read_d  = read_q;
        write_d = write_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        err_d   = err_q;
        if (illegal) err_d = sat_inc(err_q);
        if (ack_done) begin
            if (l2_op_q == OP_CLR) begin
                read_d  = '0;
                write_d = '0;
                hit_d   = '0;
                miss_d  = '0;
                err_d   = '0;
            end else if (is_l1_op(l2_op_q)) begin
                if (l2_op_q == OP_DW) write_d = sat_inc(write_q);
                else                  read_d  = sat_inc(read_q);
                if (l2_hit) hit_d  = sat_inc(hit_q);
                else        miss_d = sat_inc(miss_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_q  <= '0;
            write_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            err_q   <= '0;
        end else begin
            read_q  <= read_d;
            write_q <= write_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    assign l2_req    = l2_req_q;
    assign l2_op     = l2_op_q;
    assign l2_addr   = l2_addr_q;
    assign print_stb = print_stb_q;
    assign read_cnt  = read_q;
    assign write_cnt = write_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;
    assign err_cnt   = err_q;

`ifdef L2_TRACE_DISPATCH_LOG_EN
    l2_op_e         log_op;
    logic [CNT_W:0] log_total;

    assign log_op    = dec.op;
    assign log_total = {1'b0, hit_q} + {1'b0, miss_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (issue)
                $display("%0t l2_trace_dispatch: issue %s addr=0x%h", $time, log_op.name(), head.addr);
            if (ack_done)
                $display("%0t l2_trace_dispatch: ack %s", $time, l2_hit ? "hit" : "miss");
            if (print_stb_q) begin
                if (log_total == '0)
                    $display("%0t l2_trace_dispatch: reads=%0d writes=%0d hits=%0d misses=%0d errors=%0d hit_ratio=n/a",
                             $time, read_q, write_q, hit_q, miss_q, err_q);
                else
                    $display("%0t l2_trace_dispatch: reads=%0d writes=%0d hits=%0d misses=%0d errors=%0d hit_ratio=%0.2f%%",
                             $time, read_q, write_q, hit_q, miss_q, err_q,
                             100.0 * real'(hit_q) / real'(log_total));
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_trace_dispatch.sv
// Directed bench for l2_trace_dispatch: a decode/statistics vector table plus
// hand-written latency, full-FIFO, reset-abort and saturation sequences.
module tb_l2_trace_dispatch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_addr;
    logic        l2_req;
    logic [2:0]  l2_op;
    logic [31:0] l2_addr;
    logic        l2_ack;
    logic        l2_hit;
    logic        print_stb;
    logic [31:0] read_cnt, write_cnt, hit_cnt, miss_cnt, err_cnt;

    logic        s_in_ready, s_l2_req, s_print_stb;
    logic [2:0]  s_l2_op;
    logic [31:0] s_l2_addr;
    logic [3:0]  s_read, s_write, s_hit, s_miss, s_err;

    int n_pass  = 0;
    int n_total = 0;

    l2_trace_dispatch #(.ADDR_W(32), .DEPTH(8), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_addr(in_addr), .l2_req(l2_req), .l2_op(l2_op),
        .l2_addr(l2_addr), .l2_ack(l2_ack), .l2_hit(l2_hit), .print_stb(print_stb),
        .read_cnt(read_cnt), .write_cnt(write_cnt), .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt), .err_cnt(err_cnt)
    );

    // Narrow-counter copy driven by the same stimulus, used for saturation.
    l2_trace_dispatch #(.ADDR_W(32), .DEPTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_cmd(in_cmd), .in_addr(in_addr), .l2_req(s_l2_req), .l2_op(s_l2_op),
        .l2_addr(s_l2_addr), .l2_ack(l2_ack), .l2_hit(l2_hit), .print_stb(s_print_stb),
        .read_cnt(s_read), .write_cnt(s_write), .hit_cnt(s_hit),
        .miss_cnt(s_miss), .err_cnt(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        hit;
        logic        issue;
        logic [2:0]  op;
        logic        prt;
        int unsigned r, w, h, m, e;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else             n_pass++;
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push(input logic [3:0] c, input logic [31:0] a);
        int n = 0;
        in_valid = 1'b1;
        in_cmd   = c;
        in_addr  = a;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (l2_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(nm, l2_req, 1);
    endtask

    task automatic ack(input logic h);
        l2_hit = h;
        l2_ack = 1'b1;
        @(negedge clk);
        l2_ack = 1'b0;
        l2_hit = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_cnts(input string nm, input int unsigned r, input int unsigned w,
                              input int unsigned h, input int unsigned m, input int unsigned e);
        check({nm, "_read"},  read_cnt,  r);
        check({nm, "_write"}, write_cnt, w);
        check({nm, "_hit"},   hit_cnt,   h);
        check({nm, "_miss"},  miss_cnt,  m);
        check({nm, "_err"},   err_cnt,   e);
    endtask

    initial begin
        // cmd, addr, hit, issue, op, print, cumulative read/write/hit/miss/err
        vecs[0]  = '{4'd1,  32'h0000_2000, 1'b1, 1'b1, 3'd1, 1'b0, 0, 1, 1, 0, 0};
        vecs[1]  = '{4'd4,  32'h0000_2040, 1'b1, 1'b1, 3'd4, 1'b0, 0, 1, 1, 0, 0};
        vecs[2]  = '{4'd9,  32'h0000_0000, 1'b0, 1'b0, 3'd0, 1'b1, 0, 1, 1, 0, 0};
        vecs[3]  = '{4'd7,  32'h0000_0000, 1'b0, 1'b0, 3'd0, 1'b0, 0, 1, 1, 0, 1};
        vecs[4]  = '{4'd0,  32'h0000_3000, 1'b1, 1'b1, 3'd0, 1'b0, 1, 1, 2, 0, 1};
        vecs[5]  = '{4'd2,  32'h0000_3040, 1'b0, 1'b1, 3'd2, 1'b0, 2, 1, 2, 1, 1};
        vecs[6]  = '{4'd3,  32'h0000_4000, 1'b0, 1'b1, 3'd3, 1'b0, 2, 1, 2, 1, 1};
        vecs[7]  = '{4'd5,  32'h0000_4040, 1'b1, 1'b1, 3'd5, 1'b0, 2, 1, 2, 1, 1};
        vecs[8]  = '{4'd6,  32'h0000_4080, 1'b0, 1'b1, 3'd6, 1'b0, 2, 1, 2, 1, 1};
        vecs[9]  = '{4'd15, 32'h0000_0000, 1'b0, 1'b0, 3'd0, 1'b0, 2, 1, 2, 1, 2};
        vecs[10] = '{4'd10, 32'h0000_0000, 1'b0, 1'b0, 3'd0, 1'b0, 2, 1, 2, 1, 3};
        vecs[11] = '{4'd8,  32'h0000_50c0, 1'b1, 1'b1, 3'd7, 1'b0, 0, 0, 0, 0, 0};
        vecs[12] = '{4'd1,  32'h0000_5000, 1'b0, 1'b1, 3'd1, 1'b0, 0, 1, 0, 1, 0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_cmd   = '0;
        in_addr  = '0;
        l2_ack   = 1'b0;
        l2_hit   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_l2_req", l2_req, 0);
        check("rst_print", print_stb, 0);
        check_cnts("rst", 0, 0, 0, 0, 0);

        // Latency: push at edge N, request visible after edge N+1
        push(4'd0, 32'h0000_1040);
        check("lat_req_early", l2_req, 0);
        @(negedge clk);
        check("lat_req", l2_req, 1);
        check("lat_op", l2_op, 0);
        check("lat_addr", l2_addr, 32'h0000_1040);
        ack(1'b0);
        check("lat_req_drop", l2_req, 0);
        check_cnts("lat", 1, 0, 0, 1, 0);

        // Decode / statistics table
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            push(vecs[i].cmd, vecs[i].addr);
            check($sformatf("row%0d_req_pre", i), l2_req, 0);
            @(negedge clk);
            check($sformatf("row%0d_req", i), l2_req, vecs[i].issue);
            check($sformatf("row%0d_print", i), print_stb, vecs[i].prt);
            if (vecs[i].issue) begin
                check($sformatf("row%0d_op", i), l2_op, vecs[i].op);
                check($sformatf("row%0d_addr", i), l2_addr, vecs[i].addr);
                @(negedge clk);
                check($sformatf("row%0d_hold", i), l2_req, 1);
                ack(vecs[i].hit);
                check($sformatf("row%0d_req_drop", i), l2_req, 0);
            end else begin
                @(negedge clk);
                check($sformatf("row%0d_print_end", i), print_stb, 0);
                check($sformatf("row%0d_no_req", i), l2_req, 0);
            end
            check_cnts($sformatf("row%0d", i), vecs[i].r, vecs[i].w, vecs[i].h, vecs[i].m, vecs[i].e);
        end

        // Full FIFO: 1 op in flight + 8 stored, then a blocked 10th record
        for (int i = 0; i < 9; i++) push(4'd0, 32'h0001_0000 + 32'(i) * 32'h40);
        check("full_ready_low", in_ready, 0);
        check("full_first_req", l2_req, 1);
        check("full_first_addr", l2_addr, 32'h0001_0000);
        in_valid = 1'b1;
        in_cmd   = 4'd0;
        in_addr  = 32'h0001_0240;
        repeat (3) @(negedge clk);
        check("full_hold_ready", in_ready, 0);
        ack(1'b1);
        check("full_after_ack_ready", in_ready, 0);
        @(negedge clk);
        check("full_pop_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("full_refilled", in_ready, 0);
        for (int k = 1; k < 10; k++) begin
            wait_req($sformatf("full_req%0d", k));
            check($sformatf("full_addr%0d", k), l2_addr, 32'h0001_0000 + 32'(k) * 32'h40);
            ack(1'b1);
        end
        check("full_drained_ready", in_ready, 1);
        check_cnts("full", 10, 1, 10, 1, 0);

        // Reset while a request is outstanding
        push(4'd0, 32'h0000_7000);
        push(4'd1, 32'h0000_7040);
        push(4'd2, 32'h0000_7080);
        wait_req("rmid_req");
        check("rmid_addr", l2_addr, 32'h0000_7000);
        reset = 1'b1;
        @(negedge clk);
        check("rmid_req_low", l2_req, 0);
        reset = 1'b0;
        ack(1'b1);
        repeat (3) @(negedge clk);
        check("rmid_req_still_low", l2_req, 0);
        check("rmid_ready", in_ready, 1);
        check_cnts("rmid", 0, 0, 0, 0, 0);

        // Saturation of 4-bit counters over 17 DR hits
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(4'd0, 32'h0000_8000 + 32'(i) * 32'h40);
            wait_req($sformatf("sat_req%0d", i));
            check($sformatf("sat_addr%0d", i), s_l2_addr, 32'h0000_8000 + 32'(i) * 32'h40);
            ack(1'b1);
        end
        check("sat_hit", s_hit, 4'hf);
        check("sat_read", s_read, 4'hf);
        check("sat_miss", s_miss, 0);
        check("sat_write", s_write, 0);
        check("sat_err", s_err, 0);
        check("sat_req_idle", s_l2_req, 0);
        check("sat_ready", s_in_ready, 1);
        check("sat_print", s_print_stb, 0);
        check("sat_op", s_l2_op, 0);
        check("wide_hit", hit_cnt, 17);
        check("wide_read", read_cnt, 17);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
